add_accum_unit: RTL and testbench
=================================

# add_accum_unit

Parametrised successor to the team's combinational adders. It performs add, subtract, accumulate and clear operations on WIDTH-bit unsigned operands and returns registered results over a valid/ready handshake. It keeps a running accumulator with a sticky overflow flag and sits between an operand source and a result consumer in the datapath.

## Interface
- WIDTH, 4, operand width in bits (≥1)
- ACC_W, 8, accumulator and result width in bits (must be ≥ WIDTH+1)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operand/op present
- in_ready  out  1  unit can accept this cycle
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned; ignored by ACC and CLR
- out_valid  out  1  res is valid
- out_ready  in  1  consumer takes res
- res  out  ACC_W  result, zero-extended
- acc  out  ACC_W  current accumulator value
- ovf  out  1  sticky accumulator overflow

## Operation
- Accept occurs when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
- ADD: res = a + b, full WIDTH+1 bits; bit WIDTH is carry-out.
- SUB: res[WIDTH:0] = (a − b) mod 2^(WIDTH+1); bit WIDTH=1 indicates borrow (a<b). Upper bits are 0.
- ACC: acc_next = acc + zero-extended a; res = acc_next. If the true sum ≥ 2^ACC_W, ovf ← 1.
- CLR: acc ← 0, ovf ← 0, res = 0.
- ADD and SUB do not modify acc or ovf.
- Output register states:
  - EMPTY (out_valid=0): accept → FULL.
  - FULL: out_ready && !accept → EMPTY; out_ready && accept → FULL with the new result; !out_ready → hold.
- res, acc and ovf are stable while out_valid=1 && !out_ready.

## Timing
- Latency is 1 cycle: res appears with out_valid on the edge after accept.
- Throughput is 1 op/cycle when out_ready is held at 1.
- acc and ovf update on the same edge as res for ACC/CLR.
- Reset values (rst_n=0 at a clk edge): out_valid=0, res=0, acc=0, ovf=0. in_ready is 1 after reset.
- Reset mid-operation discards any pending result without a handshake.
- Reset has priority over accept.
- Inputs are sampled only on accept; changes to a, b or op while !in_ready are ignored.

## Configuration
- ADD_ACC_SATURATE_EN defined: on ACC overflow, acc and res clamp to 2^ACC_W−1. ovf is still set. Further ACCs hold the value at the clamp.
- ADD_ACC_SATURATE_EN undefined: on ACC overflow, acc and res wrap modulo 2^ACC_W, and ovf is set.
- ADD and SUB are unaffected by the macro.

## Test plan
All scenarios use WIDTH=4, ACC_W=8.
- ADD a=2,b=5, out_ready=1 → next cycle out_valid=1, res=7, acc=0.
- ADD a=15,b=15 → res=30 (bit4 carry=1). SUB a=3,b=5 → res=0x1E (bit4 borrow=1). SUB a=7,b=1 → res=6.
- CLR, then 17× ACC a=15 → res=acc=255, ovf=0. 18th ACC a=15 → without macro: acc=14, ovf=1; with ADD_ACC_SATURATE_EN: acc=255, ovf=1. CLR → acc=0, ovf=0.
- Back-pressure: ADD 1+1 accepted, out_ready=0 for 3 cycles with a new op presented → in_ready=0, res=2 held stable. Raise out_ready → new result on the next edge, with no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 8 ADDs a=i,b=i → 8 consecutive out_valid cycles, res=0,2,…,14.
- Reset mid-op: after ACC a=9 with out_valid=1 and out_ready=0, assert rst_n=0 for 1 cycle → out_valid=0, res=0, acc=0, ovf=0, in_ready=1.

Source files
------------

// File: rtl/add_accum_unit.sv
// Add/subtract/accumulate/clear unit with a one-entry registered result stage and valid/ready handshake.
// Optional build macro ADD_ACC_SATURATE_EN: accumulator clamps at all-ones on overflow instead of wrapping.
module add_accum_unit #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] res,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [ACC_W:0]   acc_sum;
  logic             acc_carry;
  logic [ACC_W-1:0] acc_next;

  // The output stage can take a new result whenever it is empty or is being drained this cycle.
  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // One extra bit keeps the carry of ADD and the borrow of SUB (mod 2^(WIDTH+1)).
  assign add_sum   = {1'b0, a} + {1'b0, b};
  assign sub_diff  = {1'b0, a} - {1'b0, b};
  assign acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(a);
  assign acc_carry = acc_sum[ACC_W];

`ifdef ADD_ACC_SATURATE_EN
  assign acc_next = acc_carry ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
  assign acc_next = acc_sum[ACC_W-1:0];
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    res_d   = res_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    // Operands are only looked at on accept, so a stalled source may change them freely.
    if (accept) begin
      case (op_e'(op))
        OP_ADD: res_d = ACC_W'(add_sum);
        OP_SUB: res_d = ACC_W'(sub_diff);
        OP_ACC: begin
          acc_d = acc_next;
          res_d = acc_next;
          if (acc_carry) ovf_d = 1'b1;
        end
        OP_CLR: begin
          acc_d = '0;
          ovf_d = 1'b0;
          res_d = '0;
        end
        default: res_d = res_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and takes priority over any accept in the same cycle.
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      res_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign res       = res_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_accum_unit.sv
// Scoreboard bench for add_accum_unit (WIDTH=4, ACC_W=8); honours ADD_ACC_SATURATE_EN if defined.
module tb_add_accum_unit;

  localparam int WIDTH = 4;
  localparam int ACC_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] res;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  add_accum_unit #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .acc      (acc),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int res;
    int acc;
    int ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_acc    = 0;
  int   m_ovf    = 0;
  int   consec   = 0;
  int   last_streak = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor: pops/compares retired results and pushes model results for accepted ops.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_acc  = 0;
      m_ovf  = 0;
      consec = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_res", 32'(res), 32'(e.res));
          check("sb_acc", 32'(acc), 32'(e.acc));
          check("sb_ovf", 32'(ovf), 32'(e.ovf));
        end
        consec++;
      end else begin
        if (consec != 0) last_streak = consec;
        consec = 0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int   s;
        case (op)
          2'b00: e.res = int'(a) + int'(b);
          2'b01: e.res = (int'(a) + 32 - int'(b)) % 32;
          2'b10: begin
            s = m_acc + int'(a);
            if (s > 255) begin
              m_ovf = 1;
`ifdef ADD_ACC_SATURATE_EN
              s = 255;
`else
              s = s - 256;
`endif
            end
            m_acc = s;
            e.res = s;
          end
          default: begin
            m_acc = 0;
            m_ovf = 0;
            e.res = 0;
          end
        endcase
        e.acc = m_acc;
        e.ovf = m_ovf;
        sb_q.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid low.
  task automatic send(input logic [1:0] o, input int av, input int bv);
    op       = o;
    a        = av[WIDTH-1:0];
    b        = bv[WIDTH-1:0];
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    check({pfx, "_res"},       32'(res),       32'd0);
    check({pfx, "_acc"},       32'(acc),       32'd0);
    check({pfx, "_ovf"},       32'(ovf),       32'd0);
    check({pfx, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_ovf_acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;

    // Basic ops; result must be valid on the edge right after accept.
    send(2'b00, 2, 5);
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    send(2'b00, 15, 15);
    send(2'b01, 3, 5);
    send(2'b01, 7, 1);
    idle(2);

    // Accumulate up to exactly 255, then one step past it.
    send(2'b11, 0, 0);
    for (int i = 0; i < 17; i++) send(2'b10, 15, 9);
    idle(2);
    @(negedge clk);
    check("acc_at_255", 32'(acc), 32'd255);
    check("ovf_at_255", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    send(2'b10, 15, 0);
    idle(2);
`ifdef ADD_ACC_SATURATE_EN
    exp_ovf_acc = 255;
`else
    exp_ovf_acc = 14;
`endif
    @(negedge clk);
    check("acc_after_ovf", 32'(acc), 32'(exp_ovf_acc));
    check("ovf_after_ovf", 32'(ovf), 32'd1);
    @(posedge clk);
    #1;
    send(2'b11, 0, 0);
    idle(2);
    @(negedge clk);
    check("acc_after_clr", 32'(acc), 32'd0);
    check("ovf_after_clr", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;

    // Back-pressure: held result must stay put while new operands wiggle.
    out_ready = 1'b0;
    send(2'b00, 1, 1);
    in_valid = 1'b1;
    op       = 2'b00;
    for (int i = 0; i < 3; i++) begin
      a = 4'(i + 8);
      b = 4'(i + 5);
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_res_hold",  32'(res),       32'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b00, 3, 4);
    idle(2);
    check("bp_sb_drained", 32'(sb_q.size()), 32'd0);

    // Streaming: eight back-to-back ADDs give eight consecutive results.
    for (int i = 0; i < 8; i++) send(2'b00, i, i);
    idle(3);
    check("stream_streak", 32'(last_streak), 32'd8);

    // Reset with a result pending must drop it silently.
    out_ready = 1'b0;
    send(2'b10, 9, 0);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_acc",       32'(acc),       32'd9);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(2);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
